// File: rtl/mult_stream_sched_if.sv
// rtl/mult_stream_sched_if.sv - requester, response and multiplier signals of the scheduler
interface mult_stream_sched_if;
    logic        req0_valid;
    logic [23:0] req0_a;
    logic [23:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [23:0] req1_a;
    logic [23:0] req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [47:0] rsp_product;
    logic [7:0]  mult_data;
    logic        mult_ena;
    logic [47:0] mult_product;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_product,
        input  rsp_ready,
        output mult_data, mult_ena,
        input  mult_product
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_product,
        output rsp_ready,
        input  mult_data, mult_ena,
        output mult_product
    );
endinterface

// File: rtl/mult_stream_sched.sv
// rtl/mult_stream_sched.sv - round-robin sharing of one byte-serial 24x24 multiplier
module mult_stream_sched #(
    parameter int MULT_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mult_stream_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LAST  = 3'(MULT_LAT - 1);
    localparam logic [2:0] BEAT_LAST = 3'd5;

    state_t      state, state_nxt;
    logic [2:0]  beat_cnt;
    logic [2:0]  lat_cnt;
    logic        last_grant;
    logic [23:0] a_q, b_q;
    logic        id_q;
    logic [47:0] prod_q;
    logic        grant0, grant1;
    logic        ena;
    logic [7:0]  data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= 3'd0;
            lat_cnt    <= 3'd0;
            last_grant <= 1'b1;
            a_q        <= 24'd0;
            b_q        <= 24'd0;
            id_q       <= 1'b0;
            prod_q     <= 48'd0;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                a_q        <= grant1 ? bus.req1_a : bus.req0_a;
                b_q        <= grant1 ? bus.req1_b : bus.req0_b;
                id_q       <= grant1;
                last_grant <= grant1;
            end
            if (state == SEND) begin
                beat_cnt <= (beat_cnt == BEAT_LAST) ? 3'd0 : beat_cnt + 3'd1;
            end
            if (state == WAIT) begin
                if (lat_cnt == LAT_LAST) begin
                    lat_cnt <= 3'd0;
                    prod_q  <= bus.mult_product;
                end else begin
                    lat_cnt <= lat_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        ena       = 1'b0;
        data      = 8'h00;
        unique case (state)
            IDLE: begin
                // On contention the requester that did not win last time is served.
                if (bus.req0_valid && (!bus.req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) state_nxt = SEND;
            end
            SEND: begin
                ena = 1'b1;
                unique case (beat_cnt)
                    3'd0:    data = a_q[23:16];
                    3'd1:    data = a_q[15:8];
                    3'd2:    data = a_q[7:0];
                    3'd3:    data = b_q[23:16];
                    3'd4:    data = b_q[15:8];
                    3'd5:    data = b_q[7:0];
                    default: data = 8'h00;
                endcase
                if (beat_cnt == BEAT_LAST) state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.mult_ena    = ena;
    assign bus.mult_data   = data;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_product = prod_q;
endmodule

// File: tb/tb_mult_stream_sched.sv
// tb/tb_mult_stream_sched.sv - self-checking bench with a cycle-offset model of the scheduler
module tb_mult_stream_sched;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam logic [47:0] GARB = 48'hDEAD_BEEF_0BAD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_stream_sched_if bus();
    mult_stream_sched_if bus3();

    mult_stream_sched #(.MULT_LAT(LAT))  dut  (.clk(clk), .rst(rst), .bus(bus));
    mult_stream_sched #(.MULT_LAT(LAT3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-serial multipliers: product shows on the bus exactly LAT cycles after the 6th beat.
    logic [39:0] sh1, sh3;
    int          bc1, bc3;
    logic [47:0] p1 [LAT];
    logic [47:0] p3 [LAT3];
    logic [47:0] full1, full3;

    always @(posedge clk) begin
        if (rst) begin
            bc1 <= 0;
            for (int i = 0; i < LAT; i++) p1[i] <= GARB;
        end else begin
            for (int i = 1; i < LAT; i++) p1[i] <= p1[i-1];
            p1[0] <= GARB;
            if (bus.mult_ena) begin
                full1 = {sh1, bus.mult_data};
                sh1 <= full1[39:0];
                if (bc1 == 5) p1[0] <= 48'(full1[47:24]) * 48'(full1[23:0]);
                bc1 <= (bc1 == 5) ? 0 : bc1 + 1;
            end
        end
    end
    assign bus.mult_product = p1[LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            bc3 <= 0;
            for (int i = 0; i < LAT3; i++) p3[i] <= GARB;
        end else begin
            for (int i = 1; i < LAT3; i++) p3[i] <= p3[i-1];
            p3[0] <= GARB;
            if (bus3.mult_ena) begin
                full3 = {sh3, bus3.mult_data};
                sh3 <= full3[39:0];
                if (bc3 == 5) p3[0] <= 48'(full3[47:24]) * 48'(full3[23:0]);
                bc3 <= (bc3 == 5) ? 0 : bc3 + 1;
            end
        end
    end
    assign bus3.mult_product = p3[LAT3-1];

    typedef struct { logic [23:0] a; logic [23:0] b; } op_t;
    typedef struct { logic id; logic [47:0] p; int c; } rsp_t;
    typedef struct { logic id; int c; } gnt_t;
    op_t  q0[$], q1[$];
    rsp_t rsp_log[$];
    gnt_t grant_log[$];
    logic [7:0] beat_log[$];
    bit   fire0, fire1;

    // Requester drivers: present queue head, retire it after an accept.
    always @(posedge clk) begin
        #1;
        if (fire0) void'(q0.pop_front());
        if (fire1) void'(q1.pop_front());
        bus.req0_valid = (q0.size() > 0);
        bus.req0_a     = (q0.size() > 0) ? q0[0].a : 24'h0;
        bus.req0_b     = (q0.size() > 0) ? q0[0].b : 24'h0;
        bus.req1_valid = (q1.size() > 0);
        bus.req1_a     = (q1.size() > 0) ? q1[0].a : 24'h0;
        bus.req1_b     = (q1.size() > 0) ? q1[0].b : 24'h0;
    end

    // Model: an op accepted at cycle t owns beats t+1..t+6 and responds from t+7+LAT.
    bit          m_busy, m_last;
    int          m_acc, k;
    logic [23:0] m_a, m_b;
    logic        m_id;
    logic        e_r0, e_r1, e_ena, e_rv;
    logic [7:0]  e_data;
    logic [47:0] ab;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            fire0  = 1'b0;
            fire1  = 1'b0;
        end else begin
            e_r0   = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
            e_r1   = !m_busy && bus.req1_valid && !e_r0;
            k      = cyc - m_acc;
            ab     = {m_a, m_b};
            e_ena  = m_busy && k >= 1 && k <= 6;
            e_data = e_ena ? 8'(ab >> (8 * (6 - k))) : 8'h00;
            e_rv   = m_busy && k >= 7 + LAT;
            chk("req0_ready", 64'(bus.req0_ready), 64'(e_r0));
            chk("req1_ready", 64'(bus.req1_ready), 64'(e_r1));
            chk("mult_ena", 64'(bus.mult_ena), 64'(e_ena));
            chk("mult_data", 64'(bus.mult_data), 64'(e_data));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
            if (e_rv) begin
                chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
                chk("rsp_product", 64'(bus.rsp_product), 64'(48'(m_a) * 48'(m_b)));
            end
            if (bus.mult_ena) beat_log.push_back(bus.mult_data);
            if (bus.rsp_valid && bus.rsp_ready)
                rsp_log.push_back('{id: bus.rsp_id, p: bus.rsp_product, c: cyc});
            if (bus.req0_ready || bus.req1_ready)
                grant_log.push_back('{id: bus.req1_ready, c: cyc});
            fire0 = bus.req0_ready;
            fire1 = bus.req1_ready;
            if (e_rv && bus.rsp_ready) begin
                m_busy = 1'b0;
            end else if (e_r0 || e_r1) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_id   = e_r1;
                m_last = e_r1;
                m_a    = e_r1 ? bus.req1_a : bus.req0_a;
                m_b    = e_r1 ? bus.req1_b : bus.req0_b;
            end
        end
    end

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_log.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("rsp_count", 64'(rsp_log.size()), 64'(n));
    endtask

    initial begin
        int acc, t, g0;
        rst = 1'b1;
        bus.rsp_ready   = 1'b1;
        bus3.rsp_ready  = 1'b1;
        bus3.req0_valid = 1'b0;
        bus3.req0_a     = 24'h0;
        bus3.req0_b     = 24'h0;
        bus3.req1_valid = 1'b0;
        bus3.req1_a     = 24'h0;
        bus3.req1_b     = 24'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_product", 64'(bus.rsp_product), 64'd0);
        chk("reset_mult_ena", 64'(bus.mult_ena), 64'd0);

        // Single op
        q0.push_back('{a: 24'h000003, b: 24'h000005});
        wait_rsp(1);
        chk("single_product", 64'(rsp_log[0].p), 64'h00000000000F);
        chk("single_id", 64'(rsp_log[0].id), 64'd0);
        chk("single_latency", 64'(rsp_log[0].c - grant_log[0].c), 64'd8);
        chk("beat0", 64'(beat_log[0]), 64'h00);
        chk("beat2", 64'(beat_log[2]), 64'h03);
        chk("beat5", 64'(beat_log[5]), 64'h05);
        chk("beat_count", 64'(beat_log.size()), 64'd6);

        // Extremes on requester 1
        q1.push_back('{a: 24'hFFFFFF, b: 24'hFFFFFF});
        q1.push_back('{a: 24'h123456, b: 24'h000000});
        wait_rsp(3);
        chk("max_product", 64'(rsp_log[1].p), 64'hFFFFFE000001);
        chk("max_id", 64'(rsp_log[1].id), 64'd1);
        chk("zero_product", 64'(rsp_log[2].p), 64'd0);

        // Contention
        q0.push_back('{a: 24'd2,  b: 24'd3});
        q0.push_back('{a: 24'd4,  b: 24'd5});
        q1.push_back('{a: 24'd7,  b: 24'd11});
        q1.push_back('{a: 24'd13, b: 24'd17});
        wait_rsp(7);
        chk("grant3", 64'(grant_log[3].id), 64'd0);
        chk("grant4", 64'(grant_log[4].id), 64'd1);
        chk("grant5", 64'(grant_log[5].id), 64'd0);
        chk("grant6", 64'(grant_log[6].id), 64'd1);
        chk("throughput", 64'(grant_log[4].c - grant_log[3].c), 64'd9);
        chk("cont_p3", 64'(rsp_log[3].p), 64'd6);
        chk("cont_p4", 64'(rsp_log[4].p), 64'd77);
        chk("cont_p5", 64'(rsp_log[5].p), 64'd20);
        chk("cont_p6", 64'(rsp_log[6].p), 64'd221);
        chk("cont_id4", 64'(rsp_log[4].id), 64'd1);

        // Backpressure
        bus.rsp_ready = 1'b0;
        q0.push_back('{a: 24'h000100, b: 24'h000200});
        t = 0;
        while (!bus.rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
        q1.push_back('{a: 24'd1, b: 24'd1});
        repeat (20) @(negedge clk);
        chk("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp_hold_product", 64'(bus.rsp_product), 64'h20000);
        chk("bp_req1_ready", 64'(bus.req1_ready), 64'd0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_rsp(9);
        chk("bp_product", 64'(rsp_log[7].p), 64'h20000);
        chk("bp_next_id", 64'(rsp_log[8].id), 64'd1);

        // Reset during SEND, after beat 2
        g0 = grant_log.size();
        q0.push_back('{a: 24'h000055, b: 24'h000066});
        t = 0;
        while (grant_log.size() == g0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rst_op_granted", 64'(grant_log.size()), 64'(g0 + 1));
        acc = grant_log[grant_log.size()-1].c;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < acc + 4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mult_ena", 64'(bus.mult_ena), 64'd0);
        chk("rst_mult_data", 64'(bus.mult_data), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        q0.push_back('{a: 24'h000010, b: 24'h000010});
        wait_rsp(10);
        chk("post_rst_product", 64'(rsp_log[9].p), 64'h000000000100);

        // MULT_LAT=3 instance
        @(posedge clk);
        #1;
        bus3.req0_a     = 24'h000003;
        bus3.req0_b     = 24'h000005;
        bus3.req0_valid = 1'b1;
        @(negedge clk);
        chk("lat3_accept", 64'(bus3.req0_ready), 64'd1);
        acc = cyc;
        @(posedge clk);
        #1 bus3.req0_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus3.rsp_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("lat3_latency", 64'(cyc - acc), 64'd10);
        chk("lat3_product", 64'(bus3.rsp_product), 64'h00000000000F);
        chk("lat3_id", 64'(bus3.rsp_id), 64'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
